clkdiv_multi_n: RTL and testbench

//  N_CH independent programmable clock dividers on one CLKin domain; each channel emits a 50% square wave Clkout[ch].
//  Per-channel 4-bit Sel picks the half-period from a shared divisor table.

---
 rtl/clkdiv_pkg.sv | 38 +++
 rtl/clkdiv_multi_n_if.sv | 23 ++
 rtl/clkdiv_channel.sv | 110 +++++++++++
 rtl/clkdiv_multi_n.sv | 33 +++
 tb/tb_clkdiv_multi_n.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and divisor table for the multi-channel clock divider.
// Table entries hold half-period minus one, in CLKin cycles.
package clkdiv_pkg;

  localparam int DEF_SEL_W = 4;
  localparam int DEF_CNT_W = 27;

  localparam logic [DEF_CNT_W-1:0] DIV_DEFAULT = 27'd10000;
  localparam logic [DEF_CNT_W-1:0] DIV_SEL1    = 27'd1666;
  localparam logic [DEF_CNT_W-1:0] DIV_SEL2    = 27'd999;
  localparam logic [DEF_CNT_W-1:0] DIV_SEL3    = 27'd666;
  localparam logic [DEF_CNT_W-1:0] DIV_SEL4    = 27'd499;
  localparam logic [DEF_CNT_W-1:0] DIV_SEL5    = 27'd399;
  localparam logic [DEF_CNT_W-1:0] DIV_SEL6    = 27'd333;
  localparam logic [DEF_CNT_W-1:0] DIV_SEL7    = 27'd284;
  localparam logic [DEF_CNT_W-1:0] DIV_SEL8    = 27'd249;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [DEF_CNT_W-1:0] div_lookup(input logic [DEF_SEL_W-1:0] sel);
    case (sel)
      4'd1:    return DIV_SEL1;
      4'd2:    return DIV_SEL2;
      4'd3:    return DIV_SEL3;
      4'd4:    return DIV_SEL4;
      4'd5:    return DIV_SEL5;
      4'd6:    return DIV_SEL6;
      4'd7:    return DIV_SEL7;
      4'd8:    return DIV_SEL8;
      default: return DIV_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/clkdiv_multi_n_if.sv
// Per-channel enable/select inputs and divided-clock outputs for clkdiv_multi_n.
// CLKDIV_SYNC_EN adds the one-bit Sync phase-alignment strobe.
interface clkdiv_multi_n_if #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 4
);
  logic [N_CH-1:0]       En;
  logic [N_CH*SEL_W-1:0] Sel;
`ifdef CLKDIV_SYNC_EN
  logic                  Sync;
`endif
  logic [N_CH-1:0]       Clkout;
  logic [N_CH-1:0]       Tick;
  logic [N_CH-1:0]       Busy;

`ifdef CLKDIV_SYNC_EN
  modport master (output En, Sel, Sync, input Clkout, Tick, Busy);
  modport slave  (input En, Sel, Sync, output Clkout, Tick, Busy);
`else
  modport master (output En, Sel, input Clkout, Tick, Busy);
  modport slave  (input En, Sel, output Clkout, Tick, Busy);
`endif
endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter plus IDLE/RUN/DRAIN sequencing.
// CLKdiv_SYNC_EN-style alignment is compiled in when CLKDIV_SYNC_EN is defined.
//
//   state | meaning
//   IDLE  | output parked low, counter cleared
//   RUN   | free-running square wave, divisor reloads at each half-period end
//   DRAIN | enable dropped during high phase; finish it, then park low
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             clkout,
  output logic             tick,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] table_val;
  logic             terminal;

  assign table_val = CNT_W'(div_lookup(DEF_SEL_W'(sel)));
  assign terminal  = (cnt_q == div_act_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_act_q <= CNT_W'(div_lookup('0));
      clkout_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      clkout_q  <= clkout_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    clkout_d  = clkout_q;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        clkout_d = 1'b0;
        if (en) begin
          state_d   = RUN;
          div_act_d = table_val;
        end
      end
      RUN, DRAIN: begin
        if (terminal) begin
          cnt_d     = '0;
          clkout_d  = ~clkout_q;
          div_act_d = table_val;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A low phase may be cut short; a high phase always completes.
        if (en) begin
          state_d = RUN;
        end else if (!clkout_q) begin
          state_d  = IDLE;
          cnt_d    = '0;
          clkout_d = 1'b0;
        end else if (terminal) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        clkout_d = 1'b0;
      end
    endcase
`ifdef CLKDIV_SYNC_EN
    if (sync && state_q != IDLE) begin
      cnt_d     = '0;
      clkout_d  = 1'b0;
      div_act_d = table_val;
      if (state_q == DRAIN || !en) state_d = IDLE;
      else                         state_d = RUN;
    end
`endif
    tick_d = clkout_d & ~clkout_q;
  end

  assign clkout = clkout_q;
  assign tick   = tick_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: rtl/clkdiv_multi_n.sv
// N_CH independent programmable clock dividers sharing CLKin.
// Define CLKDIV_SYNC_EN to add the Sync input that realigns all running channels.
module clkdiv_multi_n
  import clkdiv_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   CLKin,
  input  logic                   Rst,
  clkdiv_multi_n_if.slave        bus
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clkdiv_channel #(
      .SEL_W (SEL_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (CLKin),
      .rst_n  (Rst),
      .en     (bus.En[g]),
      .sel    (bus.Sel[g*SEL_W +: SEL_W]),
`ifdef CLKDIV_SYNC_EN
      .sync   (bus.Sync),
`endif
      .clkout (bus.Clkout[g]),
      .tick   (bus.Tick[g]),
      .busy   (bus.Busy[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi_n.sv
// Directed bench for clkdiv_multi_n: timing of divided clocks, select changes, drain and reset.
// Sync alignment is exercised when CLKDIV_SYNC_EN is defined.
module tb_clkdiv_multi_n;

  logic CLKin = 1'b0;
  logic Rst   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLKin = ~CLKin;

  clkdiv_multi_n_if #(.N_CH(4), .SEL_W(4)) bus ();

  clkdiv_multi_n #(.N_CH(4), .SEL_W(4), .CNT_W(27)) dut (
    .CLKin (CLKin),
    .Rst   (Rst),
    .bus   (bus)
  );

  task automatic set_sel(input int ch, input logic [3:0] v);
    bus.Sel[ch*4 +: 4] = v;
  endtask

  // Counts rising edges until Clkout[ch] reads lvl; n==limit means it never did.
  task automatic wait_level(input int ch, input logic lvl, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge CLKin); #1;
      n++;
      if (bus.Clkout[ch] === lvl) return;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b0;
    bus.En = '0;
    bus.Sel = '0;
`ifdef CLKDIV_SYNC_EN
    bus.Sync = 1'b0;
`endif
    #12;
    checks++;
    if ({bus.Clkout, bus.Busy, bus.Tick} !== 12'h000) begin
      errors++; $display("FAIL reset_outputs got %h exp 000", {bus.Clkout, bus.Busy, bus.Tick});
    end
    @(negedge CLKin); Rst = 1'b1;
    repeat (40) @(posedge CLKin);
    #1;
    checks++;
    if ({bus.Clkout, bus.Busy, bus.Tick} !== 12'h000) begin
      errors++; $display("FAIL idle_after_release got %h exp 000", {bus.Clkout, bus.Busy, bus.Tick});
    end
  endtask

  task automatic test_basic;
    int n;
    @(posedge CLKin); #1;
    set_sel(0, 4'd8);
    bus.En[0] = 1'b1;
    @(posedge CLKin); #1;
    checks++;
    if (bus.Busy[0] !== 1'b1 || bus.Clkout[0] !== 1'b0) begin
      errors++; $display("FAIL basic_busy got busy=%b clk=%b exp busy=1 clk=0", bus.Busy[0], bus.Clkout[0]);
    end
    wait_level(0, 1'b1, 600, n);
    checks++;
    if (n !== 250) begin errors++; $display("FAIL basic_first_rise got %0d exp 250", n); end
    checks++;
    if (bus.Tick[0] !== 1'b1) begin errors++; $display("FAIL basic_tick_rise got %b exp 1", bus.Tick[0]); end
    wait_level(0, 1'b0, 600, n);
    checks++;
    if (n !== 250) begin errors++; $display("FAIL basic_fall got %0d exp 250", n); end
    checks++;
    if (bus.Tick[0] !== 1'b0) begin errors++; $display("FAIL basic_tick_fall got %b exp 0", bus.Tick[0]); end
    wait_level(0, 1'b1, 600, n);
    checks++;
    if (n !== 250) begin errors++; $display("FAIL basic_second_rise got %0d exp 250", n); end
    checks++;
    if (bus.Tick[0] !== 1'b1) begin errors++; $display("FAIL basic_tick_rise2 got %b exp 1", bus.Tick[0]); end
  endtask

  // Entered right after a Clkout0 rise with Sel=8.
  task automatic test_sel_change;
    int n;
    repeat (100) @(posedge CLKin);
    #1;
    set_sel(0, 4'd4);
    wait_level(0, 1'b0, 1200, n);
    checks++;
    if (n !== 150) begin errors++; $display("FAIL selchg_current_half got %0d exp 150", n); end
    wait_level(0, 1'b1, 1200, n);
    checks++;
    if (n !== 500) begin errors++; $display("FAIL selchg_low_half got %0d exp 500", n); end
    wait_level(0, 1'b0, 1200, n);
    checks++;
    if (n !== 500) begin errors++; $display("FAIL selchg_high_half got %0d exp 500", n); end
    set_sel(0, 4'd8);
    bus.En[0] = 1'b0;
    @(posedge CLKin); #1;
    checks++;
    if (bus.Busy[0] !== 1'b0 || bus.Clkout[0] !== 1'b0) begin
      errors++; $display("FAIL disable_low got busy=%b clk=%b exp 0 0", bus.Busy[0], bus.Clkout[0]);
    end
  endtask

  task automatic test_drain;
    int n;
    @(posedge CLKin); #1;
    bus.En[0] = 1'b1;
    wait_level(0, 1'b1, 600, n);
    checks++;
    if (n !== 251) begin errors++; $display("FAIL drain_setup_rise got %0d exp 251", n); end
    repeat (10) @(posedge CLKin);
    #1; bus.En[0] = 1'b0;
    repeat (51) @(posedge CLKin);
    #1;
    checks++;
    if (bus.Busy[0] !== 1'b1 || bus.Clkout[0] !== 1'b1) begin
      errors++; $display("FAIL drain_hold got busy=%b clk=%b exp 1 1", bus.Busy[0], bus.Clkout[0]);
    end
    bus.En[0] = 1'b1;
    wait_level(0, 1'b0, 600, n);
    checks++;
    if (n !== 189 || bus.Busy[0] !== 1'b1) begin
      errors++; $display("FAIL drain_reenable_fall got n=%0d busy=%b exp n=189 busy=1", n, bus.Busy[0]);
    end
    wait_level(0, 1'b1, 600, n);
    checks++;
    if (n !== 250 || bus.Tick[0] !== 1'b1) begin
      errors++; $display("FAIL drain_reenable_rise got n=%0d tick=%b exp n=250 tick=1", n, bus.Tick[0]);
    end
    repeat (10) @(posedge CLKin);
    #1; bus.En[0] = 1'b0;
    @(posedge CLKin); #1;
    checks++;
    if (bus.Busy[0] !== 1'b1 || bus.Clkout[0] !== 1'b1) begin
      errors++; $display("FAIL drain_enter got busy=%b clk=%b exp 1 1", bus.Busy[0], bus.Clkout[0]);
    end
    wait_level(0, 1'b0, 600, n);
    checks++;
    if (n !== 239) begin errors++; $display("FAIL drain_fall got %0d exp 239", n); end
    checks++;
    if (bus.Busy[0] !== 1'b0 || bus.Tick[0] !== 1'b0) begin
      errors++; $display("FAIL drain_idle got busy=%b tick=%b exp 0 0", bus.Busy[0], bus.Tick[0]);
    end
  endtask

  task automatic test_independent;
    int first_rise [4];
    int second_rise2;
    int rises [4];
    int ticks2;
    logic [3:0] prev;
    for (int c = 0; c < 4; c++) begin first_rise[c] = -1; rises[c] = 0; end
    second_rise2 = -1;
    ticks2 = 0;
    prev = '0;
    @(posedge CLKin); #1;
    set_sel(1, 4'd0);
    set_sel(2, 4'd1);
    set_sel(3, 4'd15);
    bus.En[3:1] = 3'b111;
    for (int t = 0; t <= 10002; t++) begin
      @(posedge CLKin); #1;
      for (int c = 1; c < 4; c++) begin
        if (bus.Clkout[c] && !prev[c]) begin
          if (first_rise[c] < 0) first_rise[c] = t;
          else if (c == 2 && second_rise2 < 0) second_rise2 = t;
          rises[c]++;
        end
      end
      if (bus.Tick[2]) ticks2++;
      prev = bus.Clkout;
    end
    checks++;
    if (first_rise[2] !== 1667) begin errors++; $display("FAIL ch2_first_rise got %0d exp 1667", first_rise[2]); end
    checks++;
    if (second_rise2 !== 5001) begin errors++; $display("FAIL ch2_second_rise got %0d exp 5001", second_rise2); end
    checks++;
    if (rises[2] !== 3 || ticks2 !== 3) begin
      errors++; $display("FAIL ch2_rise_count got rises=%0d ticks=%0d exp 3 3", rises[2], ticks2);
    end
    checks++;
    if (first_rise[1] !== 10001) begin errors++; $display("FAIL ch1_sel0_rise got %0d exp 10001", first_rise[1]); end
    checks++;
    if (first_rise[3] !== 10001) begin errors++; $display("FAIL ch3_sel15_rise got %0d exp 10001", first_rise[3]); end
    checks++;
    if (bus.Busy[0] !== 1'b0 || bus.Clkout[0] !== 1'b0) begin
      errors++; $display("FAIL ch0_undisturbed got busy=%b clk=%b exp 0 0", bus.Busy[0], bus.Clkout[0]);
    end
  endtask

  // Channels 1 and 3 are mid-high-phase on entry.
  task automatic test_async_reset;
    repeat (20) @(posedge CLKin);
    #1;
    checks++;
    if (bus.Clkout[1] !== 1'b1 || bus.Busy[3] !== 1'b1) begin
      errors++; $display("FAIL areset_precond got clk1=%b busy3=%b exp 1 1", bus.Clkout[1], bus.Busy[3]);
    end
    #3 Rst = 1'b0;
    #1;
    checks++;
    if ({bus.Clkout, bus.Busy, bus.Tick} !== 12'h000) begin
      errors++; $display("FAIL areset_immediate got %h exp 000", {bus.Clkout, bus.Busy, bus.Tick});
    end
    bus.En = '0;
    @(negedge CLKin); Rst = 1'b1;
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync;
    int r0, r1;
    r0 = -1; r1 = -1;
    @(posedge CLKin); #1;
    set_sel(0, 4'd8);
    set_sel(1, 4'd4);
    bus.En[1:0] = 2'b11;
    repeat (300) @(posedge CLKin);
    #1;
    checks++;
    if (bus.Clkout[1:0] !== 2'b01) begin
      errors++; $display("FAIL sync_precond got %b exp 01", bus.Clkout[1:0]);
    end
    bus.Sync = 1'b1;
    @(posedge CLKin); #1;
    bus.Sync = 1'b0;
    checks++;
    if (bus.Clkout[1:0] !== 2'b00 || bus.Tick !== 4'b0000 || bus.Busy !== 4'b0011) begin
      errors++; $display("FAIL sync_align got clk=%b tick=%b busy=%b exp 00 0000 0011",
                         bus.Clkout[1:0], bus.Tick, bus.Busy);
    end
    for (int t = 1; t <= 501; t++) begin
      @(posedge CLKin); #1;
      if (bus.Clkout[0] && r0 < 0) r0 = t;
      if (bus.Clkout[1] && r1 < 0) r1 = t;
    end
    checks++;
    if (r0 !== 250 || r1 !== 500) begin
      errors++; $display("FAIL sync_next_rise got ch0=%0d ch1=%0d exp 250 500", r0, r1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sel_change();
    test_drain();
    test_independent();
    test_async_reset();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
